// File: rtl/booth_pkg.sv
// ============================================================================
// Module   : booth_pkg
// Purpose  : Shared types and the radix-4 Booth digit decoder for the
//            sequential Booth multiplier.
// Revision : 1.0
// ============================================================================
`default_nettype none

package booth_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    ZERO = 3'd0,
    POS1 = 3'd1,
    POS2 = 3'd2,
    NEG1 = 3'd3,
    NEG2 = 3'd4
  } booth_digit_e;

  // Bit order is {b[2i+1], b[2i], b[2i-1]}.
  function automatic booth_digit_e booth_decode(input logic [2:0] bits);
    booth_digit_e d;
    d = ZERO;
    case (bits)
      3'b001, 3'b010: d = POS1;
      3'b011:         d = POS2;
      3'b100:         d = NEG2;
      3'b101, 3'b110: d = NEG1;
      default:        d = ZERO;
    endcase
    return d;
  endfunction

endpackage

`default_nettype wire

// File: rtl/booth_r4_pp_gen.sv
// ============================================================================
// Module   : booth_r4_pp_gen
// Purpose  : Combinational partial-product generator: selects 0, +/-A or
//            +/-2A from the extended multiplicand for one Booth digit.
// Revision : 1.0
// ============================================================================
`default_nettype none

module booth_r4_pp_gen import booth_pkg::*; #(
  parameter int WIDTH = 8
) (
  input  logic [2:0]       digit,
  input  logic [WIDTH+1:0] a_ext,
  output logic [WIDTH+2:0] pp
);

  logic [WIDTH+2:0] w_a1;
  logic [WIDTH+2:0] w_a2;

  // One extra bit keeps 2A and -2A representable for every operand.
  assign w_a1 = {a_ext[WIDTH+1], a_ext};
  assign w_a2 = {a_ext, 1'b0};

  always_comb begin
    pp = '0;
    case (booth_digit_e'(digit))
      POS1:    pp = w_a1;
      POS2:    pp = w_a2;
      NEG1:    pp = -w_a1;
      NEG2:    pp = -w_a2;
      default: pp = '0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/booth_r4_seq_mult.sv
// ============================================================================
// Module   : booth_r4_seq_mult
// Purpose  : Iterative radix-4 Booth multiplier, one digit per clock, with
//            valid/ready handshakes and per-transaction signedness.
// Revision : 1.0
// ============================================================================
`default_nettype none

module booth_r4_seq_mult import booth_pkg::*; #(
  parameter int WIDTH = 8
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 signed_mode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   p,
  output logic                 busy
);

  localparam int N_ITER  = WIDTH / 2 + 1;
  localparam int c_ext_w = WIDTH + 2;
  localparam int c_pp_w  = WIDTH + 3;
  localparam int c_acc_w = 2 * WIDTH + 4;
  localparam int c_cnt_w = $clog2(N_ITER);

  generate
    if ((WIDTH % 2) != 0 || WIDTH < 4) begin : g_width_check
      $error("booth_r4_seq_mult: WIDTH must be even and >= 4");
    end
  endgenerate

  state_e               r_state;
  logic [c_ext_w-1:0]   r_a_ext;
  logic [c_ext_w:0]     r_bsh;
  logic [c_acc_w-1:0]   r_acc;
  logic [c_cnt_w-1:0]   r_cnt;

  logic [c_ext_w-1:0]   w_a_ext;
  logic [c_ext_w-1:0]   w_b_ext;
  logic [2:0]           w_digit;
  logic [c_pp_w-1:0]    w_pp;
  logic [c_acc_w-1:0]   w_pp_sx;
  logic [c_acc_w-1:0]   w_acc_next;
  logic                 w_last;

  assign w_a_ext = {{2{signed_mode & a[WIDTH-1]}}, a};
  assign w_b_ext = {{2{signed_mode & b[WIDTH-1]}}, b};

  // r_bsh holds the unconsumed multiplier bits with b[2i-1] at position 0.
  assign w_digit = booth_decode(r_bsh[2:0]);

  booth_r4_pp_gen #(
    .WIDTH (WIDTH)
  ) u_pp_gen (
    .digit (w_digit),
    .a_ext (r_a_ext),
    .pp    (w_pp)
  );

  assign w_pp_sx    = {{(c_acc_w-c_pp_w){w_pp[c_pp_w-1]}}, w_pp};
  assign w_acc_next = r_acc + (w_pp_sx << {r_cnt, 1'b0});
  assign w_last     = (r_cnt == c_cnt_w'(N_ITER - 1));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= IDLE;
      r_a_ext   <= '0;
      r_bsh     <= '0;
      r_acc     <= '0;
      r_cnt     <= '0;
      p         <= '0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
      busy      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a_ext  <= w_a_ext;
            r_bsh    <= {w_b_ext, 1'b0};
            r_acc    <= '0;
            r_cnt    <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            r_state  <= CALC;
          end
        end
        CALC: begin
          r_acc <= w_acc_next;
          r_bsh <= {{2{r_bsh[c_ext_w]}}, r_bsh[c_ext_w:2]};
          r_cnt <= r_cnt + c_cnt_w'(1);
          if (w_last) begin
            p         <= w_acc_next[2*WIDTH-1:0];
            out_valid <= 1'b1;
            r_state   <= DONE;
          end
        end
        DONE: begin
          // Result is held until the consumer takes it; no overlap with a new operand.
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            r_state   <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_booth_r4_seq_mult.sv
// ============================================================================
// Module   : tb_booth_r4_seq_mult
// Purpose  : Scoreboard bench for booth_r4_seq_mult at WIDTH=8 and WIDTH=16.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_booth_r4_seq_mult;

  localparam int N8  = 5;
  localparam int N16 = 9;

  typedef struct {
    logic [31:0] exp;
    int          acc;
  } sb_t;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;

  logic        in_valid8 = 1'b0, sm8 = 1'b0, out_ready8 = 1'b1;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        in_ready8, out_valid8, busy8;
  logic [15:0] p8;
  int          ready_mode = 1;

  logic        in_valid16 = 1'b0, sm16 = 1'b0;
  logic        out_ready16 = 1'b1;
  logic [15:0] a16 = '0, b16 = '0;
  logic        in_ready16, out_valid16, busy16;
  logic [31:0] p16;

  sb_t         q8[$];
  sb_t         q16[$];
  logic        seen8 = 1'b0, seen16 = 1'b0;
  logic [15:0] held8;
  logic [31:0] held16;

  booth_r4_seq_mult #(.WIDTH(8)) u_dut8 (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .signed_mode(sm8), .out_valid(out_valid8),
    .out_ready(out_ready8), .p(p8), .busy(busy8)
  );

  booth_r4_seq_mult #(.WIDTH(16)) u_dut16 (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid16), .in_ready(in_ready16),
    .a(a16), .b(b16), .signed_mode(sm16), .out_valid(out_valid16),
    .out_ready(out_ready16), .p(p16), .busy(busy16)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // Single driver of out_ready8: 0 = hold off, 1 = always ready, 2 = random.
  always @(posedge clock) begin
    #1;
    case (ready_mode)
      0:       out_ready8 = 1'b0;
      2:       out_ready8 = 1'($urandom_range(0, 1));
      default: out_ready8 = 1'b1;
    endcase
  end

  initial begin
    #900000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] model8(input logic [7:0] x, input logic [7:0] y, input logic sm);
    longint xa, ya;
    xa = sm ? longint'($signed(x)) : longint'(x);
    ya = sm ? longint'($signed(y)) : longint'(y);
    return 16'(xa * ya);
  endfunction

  function automatic logic [31:0] model16(input logic [15:0] x, input logic [15:0] y, input logic sm);
    longint xa, ya;
    xa = sm ? longint'($signed(x)) : longint'(x);
    ya = sm ? longint'($signed(y)) : longint'(y);
    return 32'(xa * ya);
  endfunction

  task automatic issue8(input logic [7:0] ia, input logic [7:0] ib, input logic sm, input logic [15:0] ex);
    int n = 0;
    @(posedge clock); #1;
    a8 = ia; b8 = ib; sm8 = sm; in_valid8 = 1'b1;
    forever begin
      @(negedge clock);
      if (in_ready8) break;
      n++;
      if (n > 300) begin
        checks++; errors++;
        $display("FAIL issue8_timeout actual=in_ready_low required=accept");
        in_valid8 = 1'b0;
        return;
      end
    end
    q8.push_back('{exp: {16'd0, ex}, acc: cyc + 1});
    @(posedge clock); #1;
    in_valid8 = 1'b0;
    sm8 = ~sm;
  endtask

  task automatic issue16(input logic [15:0] ia, input logic [15:0] ib, input logic sm, input logic [31:0] ex);
    int n = 0;
    @(posedge clock); #1;
    a16 = ia; b16 = ib; sm16 = sm; in_valid16 = 1'b1;
    forever begin
      @(negedge clock);
      if (in_ready16) break;
      n++;
      if (n > 300) begin
        checks++; errors++;
        $display("FAIL issue16_timeout actual=in_ready_low required=accept");
        in_valid16 = 1'b0;
        return;
      end
    end
    q16.push_back('{exp: ex, acc: cyc + 1});
    @(posedge clock); #1;
    in_valid16 = 1'b0;
    sm16 = ~sm;
  endtask

  always @(negedge clock) begin
    if (!reset_n) begin
      seen8 = 1'b0;
    end else if (out_valid8) begin
      if (!seen8) begin
        seen8 = 1'b1;
        held8 = p8;
        if (q8.size() == 0) chk("unexpected_out8", 32'(out_valid8), 32'd0);
        else chk("latency8", 32'(cyc - q8[0].acc), N8);
      end
      if (out_ready8) begin
        if (q8.size() > 0) begin
          chk("p8", {16'd0, p8}, q8[0].exp);
          chk("p8_stable", {16'd0, p8}, {16'd0, held8});
          void'(q8.pop_front());
        end
        seen8 = 1'b0;
      end
    end
  end

  always @(negedge clock) begin
    if (!reset_n) begin
      seen16 = 1'b0;
    end else if (out_valid16) begin
      if (!seen16) begin
        seen16 = 1'b1;
        held16 = p16;
        if (q16.size() == 0) chk("unexpected_out16", 32'(out_valid16), 32'd0);
        else chk("latency16", 32'(cyc - q16[0].acc), N16);
      end
      if (out_ready16) begin
        if (q16.size() > 0) begin
          chk("p16", p16, q16[0].exp);
          chk("p16_stable", p16, held16);
          void'(q16.pop_front());
        end
        seen16 = 1'b0;
      end
    end
  end

  task automatic drain();
    int n = 0;
    while ((q8.size() != 0 || q16.size() != 0) && n < 400) begin
      @(negedge clock);
      n++;
    end
    chk("drain_pending", 32'(q8.size() + q16.size()), 32'd0);
  endtask

  initial begin
    logic [7:0]  ra, rb;
    logic [15:0] ra16, rb16;
    logic        rs;
    int          n;

    repeat (3) @(posedge clock);
    #1 reset_n = 1'b1;
    repeat (3) @(negedge clock);
    chk("rst_p8", {16'd0, p8}, 32'd0);
    chk("rst_out_valid8", 32'(out_valid8), 32'd0);
    chk("rst_in_ready8", 32'(in_ready8), 32'd1);
    chk("rst_busy8", 32'(busy8), 32'd0);
    chk("rst_p16", p16, 32'd0);
    chk("rst_in_ready16", 32'(in_ready16), 32'd1);

    issue8(8'd3, 8'd7, 1'b0, 16'd21);
    issue8(8'h80, 8'h80, 1'b1, 16'h4000);
    issue8(8'h80, 8'h7F, 1'b1, 16'hC080);
    issue8(8'hFF, 8'hFF, 1'b0, 16'hFE01);
    issue8(8'hFF, 8'hFF, 1'b1, 16'h0001);
    issue8(8'h00, 8'hFF, 1'b0, 16'h0000);
    issue8(8'hF9, 8'h06, 1'b1, 16'hFFD6);
    issue8(8'hF9, 8'h06, 1'b0, 16'h05D6);
    for (int i = 1; i <= 9; i++)
      for (int j = 1; j <= 10; j++)
        issue8(8'(i), 8'(j), 1'b0, 16'(i * j));
    drain();

    // Backpressure: result must hold and a new request must be dropped.
    @(negedge clock) ready_mode = 0;
    issue8(8'd3, 8'd7, 1'b0, 16'd21);
    n = 0;
    while (!out_valid8 && n < 50) begin
      @(negedge clock);
      n++;
    end
    chk("bp_out_valid_rise", 32'(out_valid8), 32'd1);
    for (int k = 0; k < 10; k++) begin
      @(negedge clock);
      if (k == 2) begin a8 = 8'd5; b8 = 8'd5; sm8 = 1'b0; in_valid8 = 1'b1; end
      if (k == 6) in_valid8 = 1'b0;
      chk("bp_p8_hold", {16'd0, p8}, 32'd21);
      chk("bp_out_valid_hold", 32'(out_valid8), 32'd1);
      chk("bp_in_ready_low", 32'(in_ready8), 32'd0);
      chk("bp_busy", 32'(busy8), 32'd1);
    end
    @(negedge clock) ready_mode = 1;
    @(posedge clock);
    @(posedge clock); #2;
    chk("bp_release_out_valid", 32'(out_valid8), 32'd0);
    chk("bp_release_in_ready", 32'(in_ready8), 32'd1);
    chk("bp_release_busy", 32'(busy8), 32'd0);
    issue8(8'd12, 8'd11, 1'b0, 16'd132);
    drain();

    issue16(16'h8000, 16'h7FFF, 1'b1, 32'hC0008000);
    issue16(16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001);
    issue16(16'h8000, 16'h8000, 1'b1, 32'h40000000);
    drain();

    @(negedge clock) ready_mode = 2;
    for (int t = 0; t < 300; t++) begin
      ra = 8'($urandom); rb = 8'($urandom); rs = 1'(t & 1);
      repeat ($urandom_range(0, 3)) @(posedge clock);
      issue8(ra, rb, rs, model8(ra, rb, rs));
    end
    for (int t = 0; t < 40; t++) begin
      ra16 = 16'($urandom); rb16 = 16'($urandom); rs = 1'(t & 1);
      issue16(ra16, rb16, rs, model16(ra16, rb16, rs));
    end
    drain();
    @(negedge clock) ready_mode = 1;

    issue8(8'd5, 8'd5, 1'b0, 16'd25);
    drain();

    // Reset in the middle of a calculation discards it.
    issue8(8'd9, 8'd9, 1'b0, 16'd81);
    @(posedge clock); #1;
    reset_n = 1'b0;
    #1;
    chk("midrst_p8", {16'd0, p8}, 32'd0);
    chk("midrst_out_valid8", 32'(out_valid8), 32'd0);
    chk("midrst_in_ready8", 32'(in_ready8), 32'd1);
    chk("midrst_busy8", 32'(busy8), 32'd0);
    q8.delete();
    q16.delete();
    repeat (6) begin
      @(negedge clock);
      chk("midrst_no_pulse", 32'(out_valid8), 32'd0);
    end
    @(posedge clock); #1 reset_n = 1'b1;
    repeat (8) begin
      @(negedge clock);
      chk("post_rst_idle", 32'(out_valid8), 32'd0);
    end
    issue8(8'hFE, 8'h03, 1'b1, 16'hFFFA);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/booth_r4_seq_mult.md
Name: booth_r4_seq_mult

Overview:
Parametrised, iterative radix-4 (modified Booth) multiplier with a valid/ready handshake on both input and output. It supports signed and unsigned operands, selected per transaction. It retires one Booth digit per clock and holds the result until the consumer accepts it. It succeeds the fixed 8-bit MBA multiplier in the arithmetic library and is the shared multiply unit for datapaths that need runtime signedness and backpressure.

Parameters:
WIDTH, 8, operand width in bits; must be even and >= 4; an odd or smaller value is an elaboration-time $error.
N_ITER, WIDTH/2+1 (localparam), Booth digits per operation; covers the two bits of zero/sign extension.

Ports:
clock  input  1  single system clock, rising edge
reset_n  input  1  asynchronous, active-low reset
in_valid  input  1  operands presented
in_ready  output  1  block can accept operands (high only in IDLE)
a  input  WIDTH  multiplicand
b  input  WIDTH  multiplier (Booth-recoded)
signed_mode  input  1  1 = two's-complement operands, 0 = unsigned; sampled with a/b
out_valid  output  1  p holds a valid result
out_ready  input  1  consumer accepts the result
p  output  2*WIDTH  product
busy  output  1  high in CALC or DONE

Behaviour:
- Reset (async assert, sync release): state=IDLE, p=0, out_valid=0, busy=0, in_ready=1; internal accumulator and counter cleared.
- FSM states are IDLE, CALC and DONE.
- IDLE: in_ready=1. On in_valid&&in_ready at edge E0:
  - latch a and b, extended to WIDTH+2 bits (sign-extended if signed_mode=1, else zero-extended);
  - clear the accumulator and counter; go to CALC.
- CALC: at each edge, decode digit i from {b[2i+1], b[2i], b[2i-1]}, with b[-1]=0.
  - Digit map: 000/111 -> 0; 001/010 -> +A; 011 -> +2A; 100 -> -2A; 101/110 -> -A.
  - Add the partial product shifted left by 2i into an accumulator of 2*WIDTH+4 bits; sign-extend partial products to full accumulator width.
  - Increment i; on the edge processing i=N_ITER-1, load p with accumulator[2*WIDTH-1:0] and go to DONE.
- Latency: out_valid rises exactly N_ITER edges after E0 (5 for WIDTH=8). It is constant and data-independent.
- DONE: out_valid=1. p is stable while out_ready=0 (indefinite backpressure). On out_valid&&out_ready: out_valid=0 and state=IDLE on that edge. The next acceptance is possible one cycle later. There is no back-to-back overlap.
- in_valid outside IDLE is ignored; the operands are not queued.
- Result is exact modulo 2^(2*WIDTH) with no overflow for either mode.
  - Signed: -2^(W-1) * -2^(W-1) = 2^(2W-2) fits.
  - Unsigned: (2^W-1)^2 fits.
- signed_mode changes during CALC have no effect; only the latched value is used.
- p keeps its last value in IDLE; it is only updated on entry to DONE.
- Reset mid-operation aborts immediately: all outputs return to reset values and the partial result is discarded.

Decomposition:
- Package booth_pkg holds:
  - the state enum (IDLE, CALC, DONE);
  - the Booth digit enum (ZERO, POS1, POS2, NEG1, NEG2);
  - function booth_decode(3-bit) -> digit.
- One combinational sub-module, booth_r4_pp_gen: inputs digit and extended multiplicand; output a signed partial product of WIDTH+3 bits.
- The FSM, counter and accumulator stay in the top module.

Test Plan:
- Reset, then idle 3 cycles -> p=0, out_valid=0, in_ready=1, busy=0. Assert reset_n=0 at mid-CALC -> outputs return to reset values within the same cycle, with no out_valid pulse.
- WIDTH=8, unsigned, a=3, b=7, out_ready=1 -> out_valid exactly 5 edges after acceptance, p=21. Sweep a=1..9, b=1..10 -> p=a*b for all 90 pairs.
- WIDTH=8 corners:
  - signed a=-128, b=-128 -> p=0x4000;
  - signed a=-128, b=127 -> p=0xC080;
  - unsigned a=255, b=255 -> p=0xFE01;
  - signed a=-1, b=-1 -> p=0x0001;
  - unsigned a=0, b=255 -> p=0.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid -> p and out_valid stable, in_ready=0, and a new in_valid is ignored. Release -> IDLE next cycle, then the new transaction completes correctly.
- WIDTH=16 instance, signed a=-32768, b=32767 -> p=0xC0008000, latency 9 edges. Unsigned a=b=65535 -> p=0xFFFE0001.
- Random 10k transactions per mode, with random in_valid/out_ready gaps -> match the reference model a*b; latency is always N_ITER.
